// File: rtl/uart_rx_controller_if.sv
// Receive-word handshake between the UART RX controller and its consumer.
// The controller holds data/valid; the consumer drives ready.
interface uart_rx_controller_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_controller.sv
// UART receive framing controller: detects start edges on the synchronized line,
// assembles bits decided by an external bit sampler and hands words to a consumer.
module uart_rx_controller #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 raw_data,
  output logic                 sampler_rst,
  input  logic                 sampler_data,
  input  logic                 sampler_clk,
  uart_rx_controller_if.master rx,
  output logic                 framing_error,
  output logic                 overrun
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e               state_q;
  logic                 sync1_q;
  logic                 line_s_q;
  logic [1:0]           sync_vld_q;
  logic                 line_hi_q;
  logic                 sampler_rst_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 framing_error_q;
  logic                 overrun_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [CNT_W-1:0]     bit_cnt_q;

  logic line_ok_c;
  logic line_fall_c;
  logic last_bit_c;
  logic deliver_ok_c;

  // Synchronizer; sync_vld_q marks when line_s_q reflects a real post-reset sample
  // so a line held low through reset never looks like a 1->0 transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      line_s_q   <= 1'b1;
      sync_vld_q <= 2'b00;
      line_hi_q  <= 1'b0;
    end else begin
      sync1_q    <= raw_data;
      line_s_q   <= sync1_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      if (sync_vld_q[1]) begin
        line_hi_q <= line_s_q;
      end
    end
  end

  assign line_ok_c    = sync_vld_q[1];
  assign line_fall_c  = line_ok_c & line_hi_q & ~line_s_q;
  assign last_bit_c   = (bit_cnt_q == CNT_W'(DATA_BITS - 1));
  assign deliver_ok_c = ~valid_q | rx.ready;

  // Shift register with the current sample placed at bit index = counter
  always_comb begin
    shift_d = shift_q;
    for (int unsigned i = 0; i < DATA_BITS; i++) begin
      if (bit_cnt_q == CNT_W'(i)) begin
        shift_d[i] = sampler_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      sampler_rst_q   <= 1'b1;
      data_q          <= '0;
      valid_q         <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
      shift_q         <= '0;
      bit_cnt_q       <= '0;
    end else begin
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
      if (valid_q && rx.ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          sampler_rst_q <= 1'b1;
          if (line_fall_c) begin
            state_q       <= S_START;
            sampler_rst_q <= 1'b0;
          end
        end

        S_START: begin
          if (sampler_clk) begin
            if (!sampler_data) begin
              state_q   <= S_DATA;
              bit_cnt_q <= '0;
            end else begin
              state_q       <= S_IDLE;
              sampler_rst_q <= 1'b1;
            end
          end
        end

        S_DATA: begin
          if (sampler_clk) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (last_bit_c) begin
              state_q <= S_STOP;
            end
          end
        end

        // Delivery overrides the consume-clear above so a same-cycle handoff keeps valid high
        S_STOP: begin
          if (sampler_clk) begin
            sampler_rst_q <= 1'b1;
            if (sampler_data) begin
              state_q <= S_IDLE;
              if (deliver_ok_c) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              framing_error_q <= 1'b1;
              state_q         <= S_WAIT_HIGH;
            end
          end
        end

        S_WAIT_HIGH: begin
          sampler_rst_q <= 1'b1;
          if (line_ok_c && line_s_q) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q       <= S_IDLE;
          sampler_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign sampler_rst   = sampler_rst_q;
  assign rx.data       = data_q;
  assign rx.valid      = valid_q;
  assign framing_error = framing_error_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller with a behavioural 16x bit sampler.
module tb_uart_rx_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic raw_data = 1'b0;
  logic sampler_rst;
  logic sampler_data = 1'b1;
  logic sampler_clk = 1'b0;
  logic framing_error;
  logic overrun;

  int tests = 0;
  int fails = 0;

  uart_rx_controller_if #(.DATA_BITS(8)) bus ();

  uart_rx_controller #(.DATA_BITS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .raw_data     (raw_data),
    .sampler_rst  (sampler_rst),
    .sampler_data (sampler_data),
    .sampler_clk  (sampler_clk),
    .rx           (bus),
    .framing_error(framing_error),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Bit sampler: decision pulse mid-bit, then every 16 clocks
  logic [3:0] smp_cnt = 4'd0;
  always @(posedge clk) begin
    if (sampler_rst) begin
      smp_cnt      <= 4'd0;
      sampler_clk  <= 1'b0;
      sampler_data <= 1'b1;
    end else begin
      smp_cnt      <= smp_cnt + 4'd1;
      sampler_clk  <= (smp_cnt == 4'd7);
      sampler_data <= raw_data;
    end
  end

  // Event monitor sampled on the falling edge
  int         cyc = 0;
  int         last_hi = 0;
  int         lat = 0;
  int         rises = 0;
  int         vcyc = 0;
  int         fe_n = 0;
  int         ov_n = 0;
  int         srst_falls = 0;
  logic [7:0] rise_data = 8'h00;
  logic       v_prev = 1'b0;
  logic       s_prev = 1'b1;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.valid && !v_prev) begin
      rises     = rises + 1;
      rise_data = bus.data;
      lat       = cyc - last_hi;
    end
    if (sampler_clk && sampler_data) last_hi = cyc;
    if (bus.valid) vcyc = vcyc + 1;
    if (framing_error) fe_n = fe_n + 1;
    if (overrun) ov_n = ov_n + 1;
    if (s_prev && !sampler_rst) srst_falls = srst_falls + 1;
    v_prev = bus.valid;
    s_prev = sampler_rst;
  end

  task automatic drive_bit(input logic b);
    raw_data = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    raw_data = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    int f0;
    raw_data  = 1'b0;
    bus.ready = 1'b0;
    rst_n     = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if (sampler_rst !== 1'b1) begin fails++; $display("FAIL reset_sampler_rst: got %b expected 1", sampler_rst); end
    tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    tests++; if (bus.data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", bus.data); end
    tests++; if (framing_error !== 1'b0 || overrun !== 1'b0) begin fails++; $display("FAIL reset_pulses: got fe=%b ov=%b expected 0 0", framing_error, overrun); end
    f0 = srst_falls;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    tests++; if (srst_falls - f0 !== 0) begin fails++; $display("FAIL low_through_reset_start: got %0d starts expected 0", srst_falls - f0); end
    tests++; if (sampler_rst !== 1'b1) begin fails++; $display("FAIL low_through_reset_srst: got %b expected 1", sampler_rst); end
    idle(20);
  endtask

  task automatic test_frame;
    int r0, v0, fe0, ov0;
    bus.ready = 1'b1;
    r0 = rises; v0 = vcyc; fe0 = fe_n; ov0 = ov_n;
    send_frame(8'hA5, 1'b1);
    idle(10);
    tests++; if (rise_data !== 8'hA5) begin fails++; $display("FAIL frame_a5_data: got %h expected a5", rise_data); end
    tests++; if (rises - r0 !== 1 || vcyc - v0 !== 1) begin fails++; $display("FAIL frame_a5_valid: got rises=%0d cycles=%0d expected 1 1", rises - r0, vcyc - v0); end
    tests++; if (fe_n - fe0 !== 0 || ov_n - ov0 !== 0) begin fails++; $display("FAIL frame_a5_errors: got fe=%0d ov=%0d expected 0 0", fe_n - fe0, ov_n - ov0); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL frame_a5_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_glitch;
    int r0, s0, fe0;
    r0 = rises; s0 = srst_falls; fe0 = fe_n;
    raw_data = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    tests++; if (srst_falls - s0 !== 1) begin fails++; $display("FAIL glitch_start: got %0d starts expected 1", srst_falls - s0); end
    tests++; if (sampler_rst !== 1'b1) begin fails++; $display("FAIL glitch_srst: got %b expected 1", sampler_rst); end
    tests++; if (rises - r0 !== 0 || fe_n - fe0 !== 0) begin fails++; $display("FAIL glitch_outputs: got valid=%0d fe=%0d expected 0 0", rises - r0, fe_n - fe0); end
  endtask

  task automatic test_framing;
    int r0, fe0, s0;
    bus.ready = 1'b1;
    r0 = rises; fe0 = fe_n; s0 = srst_falls;
    send_frame(8'h3C, 1'b0);
    repeat (32) @(negedge clk);
    tests++; if (fe_n - fe0 !== 1) begin fails++; $display("FAIL framing_pulse: got %0d cycles expected 1", fe_n - fe0); end
    tests++; if (rises - r0 !== 0 || bus.valid !== 1'b0) begin fails++; $display("FAIL framing_valid: got rises=%0d valid=%b expected 0 0", rises - r0, bus.valid); end
    tests++; if (sampler_rst !== 1'b1 || srst_falls - s0 !== 1) begin fails++; $display("FAIL framing_wait_high: got srst=%b starts=%0d expected 1 1", sampler_rst, srst_falls - s0); end
    idle(20);
    r0 = rises;
    send_frame(8'h11, 1'b1);
    idle(10);
    tests++; if (rises - r0 !== 1 || rise_data !== 8'h11) begin fails++; $display("FAIL framing_recover: got rises=%0d data=%h expected 1 11", rises - r0, rise_data); end
  endtask

  task automatic test_overrun;
    int ov0;
    bus.ready = 1'b0;
    send_frame(8'h12, 1'b1);
    idle(10);
    tests++; if (bus.valid !== 1'b1 || bus.data !== 8'h12) begin fails++; $display("FAIL overrun_first: got valid=%b data=%h expected 1 12", bus.valid, bus.data); end
    ov0 = ov_n;
    send_frame(8'h34, 1'b1);
    idle(10);
    tests++; if (ov_n - ov0 !== 1) begin fails++; $display("FAIL overrun_pulse: got %0d cycles expected 1", ov_n - ov0); end
    tests++; if (bus.valid !== 1'b1 || bus.data !== 8'h12) begin fails++; $display("FAIL overrun_hold: got valid=%b data=%h expected 1 12", bus.valid, bus.data); end
    bus.ready = 1'b1;
    @(negedge clk);
    tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL overrun_consume: got valid=%b expected 0", bus.valid); end
    bus.ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int ov0;
    int seen;
    bus.ready = 1'b0;
    send_frame(8'hC3, 1'b1);
    idle(10);
    tests++; if (bus.valid !== 1'b1 || bus.data !== 8'hC3) begin fails++; $display("FAIL b2b_first: got valid=%b data=%h expected 1 c3", bus.valid, bus.data); end
    ov0  = ov_n;
    seen = 0;
    fork
      send_frame(8'h96, 1'b1);
      begin
        for (int c = 0; c < 400 && seen < 10; c++) begin
          @(negedge clk);
          if (sampler_clk) seen++;
        end
        bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
      end
    join
    tests++; if (seen !== 10) begin fails++; $display("FAIL b2b_sampler_pulses: got %0d expected 10", seen); end
    tests++; if (bus.valid !== 1'b1 || bus.data !== 8'h96) begin fails++; $display("FAIL b2b_handoff: got valid=%b data=%h expected 1 96", bus.valid, bus.data); end
    tests++; if (ov_n - ov0 !== 0) begin fails++; $display("FAIL b2b_overrun: got %0d expected 0", ov_n - ov0); end
    bus.ready = 1'b1;
    idle(4);
  endtask

  task automatic test_reset_midframe;
    int r0, fe0, ov0, s0;
    bus.ready = 1'b1;
    r0 = 0; fe0 = 0; ov0 = 0; s0 = 0;
    fork
      send_frame(8'h07, 1'b1);
      begin
        repeat (16 + 3 * 16 + 8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if (sampler_rst !== 1'b1 || bus.valid !== 1'b0 || bus.data !== 8'h00) begin fails++; $display("FAIL midreset_outputs: got srst=%b valid=%b data=%h expected 1 0 00", sampler_rst, bus.valid, bus.data); end
        tests++; if (framing_error !== 1'b0 || overrun !== 1'b0) begin fails++; $display("FAIL midreset_pulses: got fe=%b ov=%b expected 0 0", framing_error, overrun); end
        repeat (3) @(negedge clk);
        r0 = rises; fe0 = fe_n; ov0 = ov_n; s0 = srst_falls;
        rst_n = 1'b1;
      end
    join
    idle(30);
    tests++; if (rises - r0 !== 0 || fe_n - fe0 !== 0 || ov_n - ov0 !== 0) begin fails++; $display("FAIL midreset_after: got valid=%0d fe=%0d ov=%0d expected 0 0 0", rises - r0, fe_n - fe0, ov_n - ov0); end
    tests++; if (srst_falls - s0 !== 0) begin fails++; $display("FAIL midreset_no_start: got %0d expected 0", srst_falls - s0); end
    r0 = rises;
    send_frame(8'h5A, 1'b1);
    idle(10);
    tests++; if (rises - r0 !== 1 || rise_data !== 8'h5A) begin fails++; $display("FAIL midreset_next_frame: got rises=%0d data=%h expected 1 5a", rises - r0, rise_data); end
  endtask

  initial begin
    bus.ready = 1'b0;
    @(negedge clk);
    test_reset;
    test_frame;
    test_glitch;
    test_framing;
    test_overrun;
    test_back_to_back;
    test_reset_midframe;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
